// File: rtl/rtcore_host_bridge_if.sv
// Host/core stream bundle for rtcore_host_bridge: host ray input, core ray/result
// FIFO ports and host result output. The bridge uses the slave modport.
`ifndef RAY_WIDTH
`define RAY_WIDTH 192
`endif
`ifndef RESULT_WIDTH
`define RESULT_WIDTH 97
`endif

interface rtcore_host_bridge_if #(
  parameter int RAY_W = `RAY_WIDTH,
  parameter int RES_W = `RESULT_WIDTH,
  parameter int SEQ_W = 16
);
  logic             ray_in_valid;
  logic             ray_in_ready;
  logic [RAY_W-1:0] ray_in_data;
  logic             ray_stream_full_n;
  logic             ray_stream_write;
  logic [RAY_W-1:0] ray_stream_din;
  logic             result_stream_empty_n;
  logic             result_stream_read;
  logic [RES_W-1:0] result_stream_dout;
  logic             res_out_valid;
  logic             res_out_ready;
  logic [RES_W-1:0] res_out_data;
  logic [SEQ_W-1:0] res_out_seq;

  modport slave (
    input  ray_in_valid, ray_in_data, ray_stream_full_n,
    input  result_stream_empty_n, result_stream_dout, res_out_ready,
    output ray_in_ready, ray_stream_write, ray_stream_din,
    output result_stream_read, res_out_valid, res_out_data, res_out_seq
  );

  modport master (
    output ray_in_valid, ray_in_data, ray_stream_full_n,
    output result_stream_empty_n, result_stream_dout, res_out_ready,
    input  ray_in_ready, ray_stream_write, ray_stream_din,
    input  result_stream_read, res_out_valid, res_out_data, res_out_seq
  );
endinterface

// File: rtl/rtcore_host_bridge.sv
// Ray/result stream bridge in front of the RT core: ray FIFO with in-flight cap,
// sequence-tagged result FIFO. Optional counters under RTB_STATS_EN.
`ifndef RAY_WIDTH
`define RAY_WIDTH 192
`endif
`ifndef RESULT_WIDTH
`define RESULT_WIDTH 97
`endif

module rtcore_host_bridge #(
  parameter int RAY_W        = `RAY_WIDTH,
  parameter int RES_W        = `RESULT_WIDTH,
  parameter int RAY_DEPTH    = 4,
  parameter int RES_DEPTH    = 4,
  parameter int MAX_INFLIGHT = 64,
  parameter int SEQ_W        = 16,
  localparam int IW          = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                 clk,
  input  logic                 srst,
  rtcore_host_bridge_if.slave  bus,
  output logic [IW-1:0]        inflight,
  output logic                 idle
`ifdef RTB_STATS_EN
  ,
  output logic [31:0]          stat_rays,
  output logic [31:0]          stat_hits,
  output logic [31:0]          stat_stall
`endif
);
  localparam int RAP   = $clog2(RAY_DEPTH);
  localparam int RSP   = $clog2(RES_DEPTH);
  localparam int ENT_W = SEQ_W + RES_W;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [RAY_W-1:0] ray_mem_q [RAY_DEPTH];
  logic [RAP-1:0]   ray_wp_q, ray_rp_q;
  logic [RAP:0]     ray_cnt_q, ray_cnt_d;
  logic             ray_rdy_q, ray_push, ray_pop, ray_empty;

  logic [ENT_W-1:0] res_mem_q [RES_DEPTH];
  logic [RSP-1:0]   res_wp_q, res_rp_q;
  logic [RSP:0]     res_cnt_q, res_cnt_d;
  logic             res_rd_q, res_push, res_pop, res_empty;
  logic [ENT_W-1:0] res_head;

  logic [SEQ_W-1:0] seq_q;
  logic [IW-1:0]    infl_q, infl_d;
  logic             idle_q;

  assign ray_empty             = (ray_cnt_q == '0);
  assign ray_push              = bus.ray_in_valid && ray_rdy_q;
  assign bus.ray_in_ready      = ray_rdy_q;
  assign bus.ray_stream_write  = !ray_empty && (infl_q < IW'(MAX_INFLIGHT));
  assign ray_pop               = bus.ray_stream_write && bus.ray_stream_full_n;
  assign bus.ray_stream_din    = ray_empty ? '0 : ray_mem_q[ray_rp_q];

  assign res_empty              = (res_cnt_q == '0);
  assign bus.result_stream_read = res_rd_q;
  assign res_push               = res_rd_q && bus.result_stream_empty_n;
  assign res_head               = res_mem_q[res_rp_q];
  assign bus.res_out_valid      = !res_empty;
  assign bus.res_out_data       = res_empty ? '0 : res_head[RES_W-1:0];
  assign bus.res_out_seq        = res_empty ? '0 : res_head[ENT_W-1:RES_W];
  assign res_pop                = !res_empty && bus.res_out_ready;

  assign inflight = infl_q;
  assign idle     = idle_q;

  always_comb begin
    ray_cnt_d = ray_cnt_q;
    res_cnt_d = res_cnt_q;
    infl_d    = infl_q;
    if (ray_push && !ray_pop)      ray_cnt_d = ray_cnt_q + (RAP+1)'(1);
    else if (!ray_push && ray_pop) ray_cnt_d = ray_cnt_q - (RAP+1)'(1);
    if (res_push && !res_pop)      res_cnt_d = res_cnt_q + (RSP+1)'(1);
    else if (!res_push && res_pop) res_cnt_d = res_cnt_q - (RSP+1)'(1);
    // A capture with nothing in flight is a core protocol error: keep inflight at 0.
    if (ray_pop && !res_push)                          infl_d = infl_q + IW'(1);
    else if (!ray_pop && res_push && infl_q != '0)     infl_d = infl_q - IW'(1);
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      ray_wp_q  <= '0;
      ray_rp_q  <= '0;
      ray_cnt_q <= '0;
      ray_rdy_q <= 1'b0;
      res_wp_q  <= '0;
      res_rp_q  <= '0;
      res_cnt_q <= '0;
      res_rd_q  <= 1'b0;
      seq_q     <= '0;
      infl_q    <= '0;
      idle_q    <= 1'b1;
    end else begin
      if (ray_push) ray_wp_q <= ray_wp_q + RAP'(1);
      if (ray_pop)  ray_rp_q <= ray_rp_q + RAP'(1);
      if (res_push) res_wp_q <= res_wp_q + RSP'(1);
      if (res_pop)  res_rp_q <= res_rp_q + RSP'(1);
      if (res_push) seq_q    <= seq_q + SEQ_W'(1);
      ray_cnt_q <= ray_cnt_d;
      res_cnt_q <= res_cnt_d;
      ray_rdy_q <= (ray_cnt_d != (RAP+1)'(RAY_DEPTH));
      res_rd_q  <= (res_cnt_d != (RSP+1)'(RES_DEPTH));
      infl_q    <= infl_d;
      idle_q    <= (ray_cnt_d == '0) && (res_cnt_d == '0) && (infl_d == '0);
    end
  end

  // Payload storage carries no reset; validity is tracked by the counters above.
  always_ff @(posedge clk) begin
    if (ray_push) ray_mem_q[ray_wp_q] <= bus.ray_in_data;
    if (res_push) res_mem_q[res_wp_q] <= {seq_q, bus.result_stream_dout};
  end

`ifdef RTB_STATS_EN
  logic [31:0] stat_rays_q, stat_hits_q, stat_stall_q;

  always_ff @(posedge clk) begin
    if (srst) begin
      stat_rays_q  <= '0;
      stat_hits_q  <= '0;
      stat_stall_q <= '0;
    end else begin
      if (ray_pop) stat_rays_q <= sat_inc32(stat_rays_q);
      if (res_push && bus.result_stream_dout[0]) stat_hits_q <= sat_inc32(stat_hits_q);
      if (bus.ray_stream_write && !bus.ray_stream_full_n) stat_stall_q <= sat_inc32(stat_stall_q);
    end
  end

  assign stat_rays  = stat_rays_q;
  assign stat_hits  = stat_hits_q;
  assign stat_stall = stat_stall_q;
`endif
endmodule
